// File: rtl/hub75_bcm_scan.sv
// HUB75 1/32-scan bit-plane (BCM) driver: shifts one plane per row, latches it,
// then shows it for DISP_BASE<<plane cycles before moving to the next plane/row.
module hub75_bcm_scan #(
  parameter int WIDTH     = 64,
  parameter int ROW_BITS  = 5,
  parameter int BITS      = 4,
  parameter int DISP_BASE = 16,
  localparam int XW       = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [XW-1:0]         px_x,
  output logic [ROW_BITS-1:0]   px_y,
  input  logic [3*BITS-1:0]     px_rgb0,
  input  logic [3*BITS-1:0]     px_rgb1,
  output logic                  sclk,
  output logic                  latch,
  output logic                  blank,
  output logic [ROW_BITS-1:0]   addry,
  output logic [2:0]            rgb0,
  output logic [2:0]            rgb1,
  output logic                  frame_start
);

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SHOW_MAX = DISP_BASE << (BITS - 1);
  localparam int CW       = imax(XW + 2, $clog2(SHOW_MAX) + 1);
  localparam int BW       = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [CW-1:0] SHIFT_LAST = CW'(2 * WIDTH + 1);
  localparam logic [CW-1:0] SAMP_END   = CW'(2 * WIDTH);

  logic [1:0]          state, state_n;
  logic [CW-1:0]       cnt, cnt_n, show_last;
  logic [BW-1:0]       b, b_n;
  logic [ROW_BITS-1:0] r, r_n;
  logic                last_plane, samp, sclk_n, fs_n;
  logic [2:0]          sel0, sel1;

  assign show_last  = CW'((DISP_BASE << b) - 1);
  assign last_plane = (b == BW'(BITS - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    b_n     = b;
    r_n     = r;
    case (state)
      S_SHIFT: if (cnt == SHIFT_LAST) begin
        state_n = S_LATCH;
        cnt_n   = '0;
      end
      S_LATCH: begin
        state_n = S_SHOW;
        cnt_n   = '0;
      end
      S_SHOW: if (cnt == show_last) begin
        state_n = S_SHIFT;
        cnt_n   = '0;
        if (last_plane) begin
          b_n = '0;
          r_n = r + 1'b1;
        end else begin
          b_n = b + 1'b1;
        end
      end
      default: begin
        state_n = S_SHIFT;
        cnt_n   = '0;
      end
    endcase
  end

  // Pixel x requested at k=2x arrives at k=2x+1; capture it there so the
  // shift edge (sclk high at k=2x+3) sits in the middle of a two-cycle data eye.
  assign samp   = (state == S_SHIFT) && cnt[0] && (cnt < SAMP_END);
  assign sclk_n = (state_n == S_SHIFT) && cnt_n[0] && (cnt_n >= CW'(3));
  assign fs_n   = (state_n == S_SHOW) && (cnt_n == show_last) && (&r) && last_plane;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [BITS-1:0] ch0, ch1;
    assign ch0     = px_rgb0[c*BITS +: BITS];
    assign ch1     = px_rgb1[c*BITS +: BITS];
    assign sel0[c] = ch0[b];
    assign sel1[c] = ch1[b];
  end

  assign px_x = (state == S_SHIFT) ? cnt[XW:1] : '0;
  assign px_y = r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_SHIFT;
      cnt         <= '0;
      b           <= '0;
      r           <= '0;
      blank       <= 1'b1;
      latch       <= 1'b0;
      sclk        <= 1'b0;
      addry       <= '0;
      rgb0        <= '0;
      rgb1        <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      b           <= b_n;
      r           <= r_n;
      blank       <= (state_n != S_SHOW);
      latch       <= (state_n == S_LATCH);
      sclk        <= sclk_n;
      frame_start <= fs_n;
      if (state_n == S_LATCH) addry <= r;
      if (samp) begin
        rgb0 <= sel0;
        rgb1 <= sel1;
      end
    end
  end

endmodule
